// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// access timeouts, trap handling and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        jump,
  input  logic        branch,
  input  logic        branch_inv_cond,
  input  logic        invalid_bit,
  input  logic        exception_bit,
  input  logic        cond_raw,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_take,
  output logic        halted,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  // Count value seen during the last request cycle allowed before timing out.
  localparam logic [CntW-1:0] LastWait = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CauseNone    = 2'd0,
    CauseInvalid = 2'd1,
    CauseEcall   = 2'd2,
    CauseTimeout = 2'd3
  } cause_e;

  state_e          state_q, state_d;
  cause_e          trap_cause_q, trap_cause_d;
  logic [31:0]     instret_q, instret_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            timed_out;

  assign timed_out = (wait_cnt_q == LastWait);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      trap_cause_q <= CauseNone;
      instret_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      instret_q    <= instret_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    instret_d    = instret_q;
    wait_cnt_d   = wait_cnt_q;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_take      = 1'b0;
    halted       = 1'b0;

    case (state_q)
      StIdle: begin
        if (run) begin
          state_d    = StFetch;
          wait_cnt_d = '0;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        // An ack in the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          state_d = StDecode;
        end else if (timed_out) begin
          state_d      = StTrap;
          trap_cause_d = CauseTimeout;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDecode: begin
        if (invalid_bit) begin
          state_d      = StTrap;
          trap_cause_d = CauseInvalid;
        end else if (exception_bit) begin
          state_d      = StTrap;
          trap_cause_d = CauseEcall;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (mem_read || mem_write) begin
          state_d    = StMem;
          wait_cnt_d = '0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write;
        if (dmem_ack) begin
          state_d = StWb;
        end else if (timed_out) begin
          state_d      = StTrap;
          trap_cause_d = CauseTimeout;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StWb: begin
        rf_we     = reg_write;
        pc_we     = 1'b1;
        pc_take   = jump | (branch & (cond_raw ^ branch_inv_cond));
        instret_d = instret_q + 32'd1;
        if (run) begin
          state_d    = StFetch;
          wait_cnt_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StTrap: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign state      = state_q;
  assign trap_cause = trap_cause_q;
  assign instret    = instret_q;

endmodule
